// File: rtl/digital_lf_gearshift.sv
// PI loop filter for a PLL DCO word, with frequency-detector pull-in and FREQ/ACQ/TRACK gear shifting.
// One-sample latency from an en edge to out; accumulator and output clamp to [0, 2^OUT_W-1].
module digital_lf_gearshift #(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 13,
  parameter int KP_ACQ  = 64,
  parameter int KI_ACQ  = 4,
  parameter int KP_TRK  = 32,
  parameter int KI_TRK  = 1,
  parameter int KF      = 256,
  parameter int INIT    = 1 << (OUT_W - 1),
  parameter int QUIET_N = 64,
  parameter int LOCK_TH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic signed [IN_W-1:0] in,
  input  logic                   fup,
  input  logic                   fdn,
  output logic [OUT_W-1:0]       out,
  output logic [1:0]             state,
  output logic                   locked
);

  localparam int W     = OUT_W + IN_W + 10;
  localparam int CNT_W = $clog2(QUIET_N + 1);

  localparam logic signed [W-1:0] KP_A  = W'(KP_ACQ);
  localparam logic signed [W-1:0] KI_A  = W'(KI_ACQ);
  localparam logic signed [W-1:0] KP_T  = W'(KP_TRK);
  localparam logic signed [W-1:0] KI_T  = W'(KI_TRK);
  localparam logic signed [W-1:0] KF_X  = W'(KF);
  localparam logic signed [W-1:0] TH_X  = W'(LOCK_TH);
  localparam logic signed [W-1:0] MAX_V = W'((1 << OUT_W) - 1);
  localparam logic [CNT_W-1:0]    QN    = CNT_W'(QUIET_N);

  typedef enum logic [1:0] {
    S_FREQ  = 2'b00,
    S_ACQ   = 2'b01,
    S_TRACK = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             locked_q, locked_d;

  logic                fd_evt, reached;
  logic signed [W-1:0] in_x, in_abs, acc_x, fd_x, kp, ki, acc_sum, out_sum;

  function automatic logic [OUT_W-1:0] sat(input logic signed [W-1:0] v);
    if (v < 0)          return '0;
    else if (v > MAX_V) return '1;
    else                return v[OUT_W-1:0];
  endfunction

  // Datapath: gains follow the pre-edge state, so a transition sample still uses the old gears.
  always_comb begin
    in_x   = W'(in);
    in_abs = in_x[W-1] ? -in_x : in_x;
    acc_x  = {{(W - OUT_W){1'b0}}, acc_q};
    fd_evt = fup ^ fdn;
    fd_x   = '0;
    if (fup && !fdn)      fd_x = KF_X;
    else if (fdn && !fup) fd_x = -KF_X;
    if (state_q == S_TRACK) begin
      kp   = KP_T;
      ki   = KI_T;
      fd_x = '0;
    end else begin
      kp = KP_A;
      ki = KI_A;
    end
    acc_sum = acc_x + ki * in_x + fd_x;
    out_sum = acc_x + kp * in_x;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FREQ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state and quiet counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == QN) ? cnt_q : cnt_q + CNT_W'(1);
    reached = (cnt_inc == QN);
    if (en) begin
      case (state_q)
        S_FREQ: begin
          if (fd_evt) begin
            cnt_d = '0;
          end else if (reached) begin
            state_d = S_ACQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_ACQ: begin
          if (fd_evt) begin
            state_d = S_FREQ;
            cnt_d   = '0;
          end else if (in_abs <= TH_X) begin
            if (reached) begin
              state_d = S_TRACK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        S_TRACK: begin
          if (fd_evt) state_d = S_FREQ;
          cnt_d = '0;
        end
        default: begin
          state_d = S_FREQ;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM outputs and filter updates
  always_comb begin
    locked_d = (state_d == S_TRACK);
    acc_d    = acc_q;
    out_d    = out_q;
    if (en) begin
      acc_d = sat(acc_sum);
      out_d = sat(out_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= OUT_W'(INIT);
      out_q    <= OUT_W'(INIT);
      locked_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      out_q    <= out_d;
      locked_q <= locked_d;
    end
  end

  assign out    = out_q;
  assign state  = state_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_digital_lf_gearshift.sv
// Directed bench for digital_lf_gearshift with hand-computed expectations at default parameters.
module tb_digital_lf_gearshift;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic signed [3:0] in_v = '0;
  logic              fup = 1'b0;
  logic              fdn = 1'b0;
  logic [12:0]       out;
  logic [1:0]        state;
  logic              locked;

  int checks = 0;
  int errors = 0;

  digital_lf_gearshift dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .in    (in_v),
    .fup   (fup),
    .fdn   (fdn),
    .out   (out),
    .state (state),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int i, input logic u, input logic d);
    in_v = 4'(i);
    fup  = u;
    fdn  = d;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en   = 1'b0;
  endtask

  // Reset with hostile inputs present to show they are ignored.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    en    = 1'b1;
    fup   = 1'b1;
    in_v  = 4'sd7;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    en    = 1'b0;
    fup   = 1'b0;
    in_v  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  prev;
    logic wrapped;

    // 1: reset
    do_reset(2);
    check("rst_out", int'(out), 4096);
    check("rst_state", int'(state), 0);
    check("rst_locked", int'(locked), 0);
    sample(0, 0, 0);
    check("rst_acc", int'(out), 4096);

    // 2: single FD steps in FREQ
    sample(0, 1, 0);
    check("fup_out_same", int'(out), 4096);
    sample(0, 0, 0);
    check("fup_out_next", int'(out), 4352);
    sample(0, 0, 1);
    sample(0, 0, 0);
    check("fdn_back", int'(out), 4096);

    // 3: saturation both ways
    wrapped = 1'b0;
    prev    = int'(out);
    for (int k = 0; k < 20; k++) begin
      sample(0, 1, 0);
      if (int'(out) < prev) wrapped = 1'b1;
      prev = int'(out);
    end
    check("sat_hi", int'(out), 8191);
    check("no_wrap_up", int'(wrapped), 0);
    wrapped = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sample(-8, 0, 1);
      if (int'(out) > prev) wrapped = 1'b1;
      prev = int'(out);
    end
    check("sat_lo", int'(out), 0);
    check("no_wrap_dn", int'(wrapped), 0);

    // 4: gear shift FREQ -> ACQ -> TRACK
    do_reset(2);
    for (int k = 0; k < 63; k++) sample(0, 0, 0);
    check("freq_63", int'(state), 0);
    sample(0, 0, 0);
    check("acq_64", int'(state), 1);
    check("acq_out", int'(out), 4096);
    for (int k = 0; k < 63; k++) sample((k % 2 == 0) ? 2 : -2, 0, 0);
    check("acq_63", int'(state), 1);
    sample(-2, 0, 0);
    check("trk_state", int'(state), 2);
    check("trk_locked", int'(locked), 1);
    check("trk_last_acq_out", int'(out), 3976);
    sample(1, 0, 0);
    check("trk_in1_a", int'(out), 4128);
    sample(1, 0, 0);
    check("trk_in1_b", int'(out), 4129);
    sample(0, 0, 0);
    check("trk_acc", int'(out), 4098);

    // 6: simultaneous FD and slip
    sample(0, 1, 1);
    check("both_state", int'(state), 2);
    sample(0, 0, 1);
    check("slip_state", int'(state), 0);
    check("slip_locked", int'(locked), 0);
    sample(0, 0, 0);
    check("slip_acc", int'(out), 4098);

    // 5: ACQ counter clear on one noisy sample
    for (int k = 0; k < 63; k++) sample(0, 0, 0);
    check("reacq", int'(state), 1);
    for (int k = 0; k < 63; k++) sample(0, 0, 0);
    sample(3, 0, 0);
    for (int k = 0; k < 63; k++) sample(0, 0, 0);
    check("acq_cleared", int'(state), 1);
    sample(0, 0, 0);
    check("acq_64_consec", int'(state), 2);

    // 6: reset in the middle of ACQ
    sample(0, 0, 1);
    for (int k = 0; k < 64; k++) sample(0, 0, 0);
    check("pre_abort_acq", int'(state), 1);
    for (int k = 0; k < 3; k++) sample(1, 0, 0);
    do_reset(1);
    check("abort_out", int'(out), 4096);
    check("abort_state", int'(state), 0);
    check("abort_locked", int'(locked), 0);
    sample(0, 0, 0);
    check("abort_acc", int'(out), 4096);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
